// File: rtl/imm_gen_stage.sv
// Decode-stage immediate producer: classifies RV32I opcodes, extracts sign-extended immediates,
// and delivers results through a 2-entry skid buffer. Optional illegal-opcode flag: IMM_GEN_ILLEGAL_EN.
package imm_gen_pkg;
   typedef enum logic [2:0] {
      IMM_TYPE_R,
      IMM_TYPE_I,
      IMM_TYPE_S,
      IMM_TYPE_B,
      IMM_TYPE_U,
      IMM_TYPE_J
   } imm_sel_e;
endpackage

module imm_gen_stage
   import imm_gen_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SKID_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [31:0]           inst_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output imm_sel_e              ImmSel_o,
   output logic [DATA_WIDTH-1:0] imm_o,
`ifdef IMM_GEN_ILLEGAL_EN
   output logic                  illegal_o,
`endif
   output logic [31:0]           inst_o
);

   typedef enum logic [1:0] {
      BUF_EMPTY,
      BUF_ONE,
      BUF_TWO
   } buf_state_e;

   buf_state_e state_q, state_d;

   imm_sel_e              dec_sel;
   logic [DATA_WIDTH-1:0] dec_imm;

   imm_sel_e              head_sel, skid_sel;
   logic [DATA_WIDTH-1:0] head_imm, skid_imm;
   logic [31:0]           head_inst, skid_inst;
`ifdef IMM_GEN_ILLEGAL_EN
   logic                  dec_illegal;
   logic                  head_illegal, skid_illegal;
`endif

   logic       push, pop;
   logic       load_head, head_from_skid, load_skid;
   logic [1:0] occupancy;

   always_comb begin
      dec_sel = IMM_TYPE_R;
      dec_imm = '0;
`ifdef IMM_GEN_ILLEGAL_EN
      dec_illegal = 1'b0;
`endif
      case (inst_i[6:0])
         7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
            dec_sel = IMM_TYPE_I;
            dec_imm = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[31:20]};
         end
         7'b0100011: begin
            dec_sel = IMM_TYPE_S;
            dec_imm = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
         end
         7'b1100011: begin
            dec_sel = IMM_TYPE_B;
            dec_imm = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[7], inst_i[30:25],
                       inst_i[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            dec_sel = IMM_TYPE_U;
            dec_imm = {{(DATA_WIDTH-32){inst_i[31]}}, inst_i[31:12], 12'b0};
         end
         7'b1101111: begin
            dec_sel = IMM_TYPE_J;
            dec_imm = {{(DATA_WIDTH-20){inst_i[31]}}, inst_i[19:12], inst_i[20],
                       inst_i[30:21], 1'b0};
         end
         7'b0110011: begin
            dec_sel = IMM_TYPE_R;
         end
         default: begin
`ifdef IMM_GEN_ILLEGAL_EN
            dec_illegal = 1'b1;
`endif
         end
      endcase
   end

   // ready_o depends only on the buffer state register, never on ready_i
   always_comb begin
      case (state_q)
         BUF_EMPTY: occupancy = 2'd0;
         BUF_ONE:   occupancy = 2'd1;
         default:   occupancy = 2'd2;
      endcase
   end

   assign ready_o = (32'(occupancy) < SKID_DEPTH);
   assign valid_o = (state_q != BUF_EMPTY);
   assign push    = valid_i & ready_o;
   assign pop     = valid_o & ready_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BUF_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      load_head      = 1'b0;
      head_from_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
         BUF_EMPTY: begin
            if (push) begin
               state_d   = BUF_ONE;
               load_head = 1'b1;
            end
         end
         BUF_ONE: begin
            if (push && pop) begin
               load_head = 1'b1;
            end else if (push) begin
               state_d   = BUF_TWO;
               load_skid = 1'b1;
            end else if (pop) begin
               state_d = BUF_EMPTY;
            end
         end
         default: begin
            if (pop) begin
               state_d        = BUF_ONE;
               load_head      = 1'b1;
               head_from_skid = 1'b1;
            end
         end
      endcase
      // Flush overrides everything, including an input presented this cycle
      if (flush_i) begin
         state_d        = BUF_EMPTY;
         load_head      = 1'b0;
         head_from_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_sel  <= IMM_TYPE_R;
         head_imm  <= '0;
         head_inst <= '0;
         skid_sel  <= IMM_TYPE_R;
         skid_imm  <= '0;
         skid_inst <= '0;
      end else begin
         if (load_head) begin
            if (head_from_skid) begin
               head_sel  <= skid_sel;
               head_imm  <= skid_imm;
               head_inst <= skid_inst;
            end else begin
               head_sel  <= dec_sel;
               head_imm  <= dec_imm;
               head_inst <= inst_i;
            end
         end
         if (load_skid) begin
            skid_sel  <= dec_sel;
            skid_imm  <= dec_imm;
            skid_inst <= inst_i;
         end
      end
   end

`ifdef IMM_GEN_ILLEGAL_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_illegal <= 1'b0;
         skid_illegal <= 1'b0;
      end else begin
         if (load_head) begin
            head_illegal <= head_from_skid ? skid_illegal : dec_illegal;
         end
         if (load_skid) begin
            skid_illegal <= dec_illegal;
         end
      end
   end

   assign illegal_o = head_illegal;
`endif

   assign ImmSel_o = head_sel;
   assign imm_o    = head_imm;
   assign inst_o   = head_inst;

endmodule
